// File: rtl/lfsr_16_checker.sv
// Lock detector and error counter for a received 16-bit LFSR word stream.
// Acquires on a nonzero seed, verifies LOCK_COUNT predictions, then counts mismatches.
module lfsr_16_checker #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      data_in,
    input  logic             valid_in,
    input  logic             clear_in,
    output logic             locked_out,
    output logic             err_pulse_out,
    output logic [ERR_W-1:0] err_count_out,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Counters only need to reach their thresholds; they are cleared on the deciding word.
    localparam int unsigned MATCH_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int unsigned LOSS_W  = (LOSS_COUNT < 1) ? 1 : $clog2(LOSS_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [LOSS_W-1:0]  LOSS_DROP  = LOSS_W'(LOSS_COUNT);

    state_t             state_q, state_d;
    logic [15:0]        exp_q, exp_d;
    logic [MATCH_W-1:0] match_q, match_d, match_inc;
    logic [LOSS_W-1:0]  loss_q, loss_d, loss_inc;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               pulse_q, locked_q;
    logic               hit, word_err;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n[0]    = s[15];
        n[1]    = s[0];
        n[2]    = s[1] ^ s[15];
        n[14:3] = s[13:2];
        n[15]   = s[14] ^ s[15];
        return n;
    endfunction

    assign hit       = (data_in == exp_q);
    assign match_inc = match_q + MATCH_W'(1);
    assign loss_inc  = loss_q + LOSS_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        match_d  = match_q;
        loss_d   = loss_q;
        word_err = 1'b0;
        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    // The all-zero word is the LFSR lock-up state and can never seed a prediction.
                    if (data_in != 16'h0000) begin
                        exp_d   = lfsr_next(data_in);
                        match_d = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        exp_d = lfsr_next(exp_q);
                        if (match_inc == MATCH_LOCK) begin
                            match_d = '0;
                            loss_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_inc;
                        end
                    end else if (data_in != 16'h0000) begin
                        exp_d   = lfsr_next(data_in);
                        match_d = '0;
                    end else begin
                        match_d = '0;
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Free-run the prediction so corrupted words never steer it.
                    exp_d = lfsr_next(exp_q);
                    if (hit) begin
                        loss_d = '0;
                    end else begin
                        word_err = 1'b1;
                        if (loss_inc == LOSS_DROP) begin
                            loss_d  = '0;
                            state_d = SEARCH;
                        end else begin
                            loss_d = loss_inc;
                        end
                    end
                end
                default: begin
                    match_d = '0;
                    loss_d  = '0;
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (clear_in) begin
            err_d = '0;
        end else if (word_err && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= SEARCH;
            exp_q    <= 16'h0000;
            match_q  <= '0;
            loss_q   <= '0;
            err_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            err_q    <= err_d;
            pulse_q  <= word_err;
            locked_q <= (state_d == LOCKED);
        end
    end

    assign locked_out    = locked_q;
    assign err_pulse_out = pulse_q;
    assign err_count_out = err_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_lfsr_16_checker.sv
// Self-checking bench for lfsr_16_checker: directed scenarios plus a randomized stream
// compared against a word-level reference model.
module tb_lfsr_16_checker;

    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned LOSS_COUNT = 3;
    localparam int unsigned ERR_W      = 4;
    localparam int          ERR_MAX    = (1 << ERR_W) - 1;
    localparam int          VEC_W      = ERR_W + 4;
    localparam logic [15:0] SEQ_8000 [5] = '{16'h8000, 16'h8005, 16'h800F, 16'h801B, 16'h8033};

    logic             clk_in   = 1'b0;
    logic             rst_in   = 1'b1;
    logic [15:0]      data_in  = 16'h0000;
    logic             valid_in = 1'b0;
    logic             clear_in = 1'b0;
    logic             locked_out, err_pulse_out;
    logic [ERR_W-1:0] err_count_out;
    logic [1:0]       state_out;
    logic [VEC_W-1:0] obs;

    int errors = 0;
    int checks = 0;

    int          m_state;
    logic [15:0] m_exp;
    int          m_match, m_loss, m_err;
    bit          m_pulse;
    logic [15:0] good;

    lfsr_16_checker #(
        .LOCK_COUNT(LOCK_COUNT),
        .LOSS_COUNT(LOSS_COUNT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .clear_in     (clear_in),
        .locked_out   (locked_out),
        .err_pulse_out(err_pulse_out),
        .err_count_out(err_count_out),
        .state_out    (state_out)
    );

    always #5 clk_in = ~clk_in;

    assign obs = {locked_out, err_pulse_out, state_out, err_count_out};

    // Galois view of the successor: rotate left, then fold the old MSB into taps 2 and 15.
    function automatic logic [15:0] nx(input logic [15:0] s);
        return {s[14:0], s[15]} ^ (s[15] ? 16'h8004 : 16'h0000);
    endfunction

    function automatic logic [VEC_W-1:0] want();
        return {(m_state == 2), m_pulse, 2'(m_state), ERR_W'(m_err)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = 16'h0000; m_match = 0; m_loss = 0; m_err = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        bit bad;
        bad     = 0;
        m_pulse = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 0) begin m_exp = nx(d); m_match = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = nx(m_exp);
                    m_match++;
                    if (m_match == LOCK_COUNT) begin m_state = 2; m_match = 0; m_loss = 0; end
                end else if (d != 0) begin
                    m_exp = nx(d); m_match = 0;
                end else begin
                    m_state = 0; m_match = 0;
                end
            end else begin
                bad   = (d != m_exp);
                m_exp = nx(m_exp);
                if (bad) begin
                    m_pulse = 1;
                    m_loss++;
                    if (m_loss == LOSS_COUNT) begin m_state = 0; m_loss = 0; end
                end else begin
                    m_loss = 0;
                end
            end
        end
        if (c) m_err = 0;
        else if (bad && m_err < ERR_MAX) m_err++;
    endtask

    task automatic cycle(input bit v, input logic [15:0] d, input bit c);
        valid_in = v; data_in = d; clear_in = c;
        @(posedge clk_in);
        if (!rst_in) model_reset();
        else model_step(v, d, c);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        #3;
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic acquire(input logic [15:0] seed, input string tag);
        logic [15:0] w;
        w = seed;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w, 1'b0);
            w = nx(w);
            checks++;
            if (obs !== want()) begin
                errors++;
                $display("FAIL %s_acq[%0d]: got %h want %h", tag, i, obs, want());
            end
            checks++;
            if (locked_out !== (i == 4)) begin
                errors++;
                $display("FAIL %s_lock[%0d]: locked_out got %b want %b", tag, i, locked_out, (i == 4));
            end
        end
        good = w;
    endtask

    task automatic test_reset();
        #1;
        rst_in = 1'b0; valid_in = 1'b1; data_in = 16'h8000; clear_in = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", obs); end
        @(posedge clk_in); #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_held_valid: got %h want 0", obs); end
        rst_in = 1'b1;
        model_reset();
    endtask

    task automatic test_lock_8000();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, SEQ_8000[i], 1'b0);
            checks++;
            if (obs !== want()) begin errors++; $display("FAIL lock8000[%0d]: got %h want %h", i, obs, want()); end
            checks++;
            if (locked_out !== (i == 4)) begin
                errors++;
                $display("FAIL lock8000_time[%0d]: locked_out got %b want %b", i, locked_out, (i == 4));
            end
        end
        checks++;
        if (state_out !== 2'd2) begin errors++; $display("FAIL lock8000_state: got %0d want 2", state_out); end
        good = nx(SEQ_8000[4]);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, good, 1'b0);
            good = nx(good);
            checks++;
            if (err_count_out !== '0 || locked_out !== 1'b1) begin
                errors++;
                $display("FAIL lock8000_hold[%0d]: err %0d locked %b want 0 1", i, err_count_out, locked_out);
            end
        end
    endtask

    task automatic test_seed_0001();
        logic [15:0] w;
        do_reset();
        w = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, w, 1'b0);
            w = nx(w);
            checks++;
            if (locked_out !== (i == 4)) begin
                errors++;
                $display("FAIL seed0001_gap[%0d]: locked_out got %b want %b", i, locked_out, (i == 4));
            end
            cycle(1'b0, 16'($urandom), 1'b0);
            checks++;
            if (obs !== want() || locked_out !== (i == 4)) begin
                errors++;
                $display("FAIL seed0001_idle[%0d]: got %h want %h", i, obs, want());
            end
        end
        good = w;
    endtask

    task automatic test_single_error();
        do_reset();
        acquire(16'hACE1, "single");
        cycle(1'b1, good ^ 16'h0080, 1'b0);
        good = nx(good);
        checks++;
        if (err_pulse_out !== 1'b1 || err_count_out !== ERR_W'(1) || locked_out !== 1'b1) begin
            errors++;
            $display("FAIL single_err: pulse %b count %0d locked %b want 1 1 1", err_pulse_out, err_count_out, locked_out);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, good, 1'b0);
            good = nx(good);
            checks++;
            if (err_pulse_out !== 1'b0 || err_count_out !== ERR_W'(1) || locked_out !== 1'b1) begin
                errors++;
                $display("FAIL single_after[%0d]: pulse %b count %0d locked %b want 0 1 1", i, err_pulse_out, err_count_out, locked_out);
            end
        end
    endtask

    task automatic test_loss();
        do_reset();
        acquire(16'h1234, "loss");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, good ^ 16'h0080, 1'b0);
            good = nx(good);
            checks++;
            if (err_count_out !== ERR_W'(k + 1) || state_out !== ((k == 2) ? 2'd0 : 2'd2)) begin
                errors++;
                $display("FAIL loss_err[%0d]: count %0d state %0d want %0d %0d", k, err_count_out, state_out, k + 1, (k == 2) ? 0 : 2);
            end
        end
        acquire(good, "relock");
    endtask

    task automatic test_zero_search();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'h0000, 1'b0);
            checks++;
            if (state_out !== 2'd0) begin errors++; $display("FAIL zero_search[%0d]: state %0d want 0", i, state_out); end
        end
        cycle(1'b1, 16'h1234, 1'b0);
        checks++;
        if (state_out !== 2'd1) begin errors++; $display("FAIL zero_load: state %0d want 1", state_out); end
        cycle(1'b1, 16'h0000, 1'b0);
        checks++;
        if (state_out !== 2'd0) begin errors++; $display("FAIL zero_verify: state %0d want 0", state_out); end
    endtask

    task automatic test_saturation_clear();
        do_reset();
        acquire(16'hBEEF, "sat");
        for (int k = 0; k < ERR_MAX + 1; k++) begin
            cycle(1'b1, good ^ 16'h0080, 1'b0);
            good = nx(good);
            checks++;
            if (err_count_out !== ERR_W'((k + 1 > ERR_MAX) ? ERR_MAX : k + 1)) begin
                errors++;
                $display("FAIL sat_count[%0d]: got %0d", k, err_count_out);
            end
            cycle(1'b1, good, 1'b0);
            good = nx(good);
        end
        checks++;
        if (err_count_out !== '1 || locked_out !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: count %0d locked %b want all-ones 1", err_count_out, locked_out);
        end
        cycle(1'b1, good ^ 16'h0080, 1'b1);
        good = nx(good);
        checks++;
        if (err_count_out !== '0 || err_pulse_out !== 1'b1) begin
            errors++;
            $display("FAIL clear_prio: count %0d pulse %b want 0 1", err_count_out, err_pulse_out);
        end
        cycle(1'b1, good ^ 16'h0100, 1'b0);
        good = nx(good);
        checks++;
        if (err_count_out !== ERR_W'(1)) begin errors++; $display("FAIL clear_recount: count %0d want 1", err_count_out); end
        cycle(1'b0, good, 1'b1);
        checks++;
        if (obs !== want() || err_count_out !== '0) begin
            errors++;
            $display("FAIL clear_idle: got %h want %h", obs, want());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        acquire(16'h5A5A, "arst");
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL arst_immediate: got %h want 0", obs); end
        cycle(1'b1, good, 1'b0);
        good = nx(good);
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL arst_held: got %h want 0", obs); end
        #3;
        rst_in = 1'b1;
        acquire(good, "arst_reacq");
    endtask

    task automatic test_random();
        bit          v, c;
        int          r;
        logic [15:0] d;
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(40) == 0);
            r = $urandom_range(39);
            if (r == 0)      d = 16'h0000;
            else if (r == 1) d = 16'($urandom);
            else if (r < 5)  d = good ^ (16'h0001 << $urandom_range(15));
            else             d = good;
            cycle(v, d, c);
            if (v) good = nx(good);
            checks++;
            if (obs !== want()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", n, obs, want());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_8000();
        test_seed_0001();
        test_single_error();
        test_loss();
        test_zero_search();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_16_checker.md
LFSR_16_CHECKER -- requirements
Module: lfsr_16_checker

Interface
REQ-001 Parameters SHALL be:
- LOCK_COUNT, default 4: consecutive matching words needed to declare lock.
- LOSS_COUNT, default 3: consecutive mismatching words that force loss of lock.
- ERR_W, default 16: width of the error counter.

REQ-002 Ports SHALL be:
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- data_in  input  16  received LFSR word.
- valid_in  input  1  data_in is valid this cycle.
- clear_in  input  1  synchronous clear of err_count_out.
- locked_out  output  1  checker is in LOCKED state.
- err_pulse_out  output  1  one-cycle flag for a mismatching word while LOCKED.
- err_count_out  output  ERR_W  saturating count of mismatches while LOCKED.
- state_out  output  2  current state: 0 SEARCH, 1 VERIFY, 2 LOCKED.

Function
REQ-003 next(s) SHALL be: n[0]=s[15]; n[1]=s[0]; n[2]=s[1]^s[15]; n[i]=s[i-1] for i=3..14; n[15]=s[14]^s[15].
REQ-004 An internal 16-bit register exp SHALL hold the predicted next word; a word "matches" when valid_in=1 and data_in==exp.
REQ-005 Cycles with valid_in=0 SHALL change no state, counter or exp, and SHALL drive err_pulse_out=0.
REQ-006 In SEARCH, a valid word != 16'h0000 SHALL load exp<=next(data_in), clear the match counter, and enter VERIFY.
REQ-007 In SEARCH, data_in==16'h0000 SHALL be ignored (lock-up state), leaving the block in SEARCH.
REQ-008 In VERIFY, a match SHALL set exp<=next(exp) and increment the match counter.
REQ-009 In VERIFY, when the match counter reaches LOCK_COUNT, the state SHALL go to LOCKED on that same edge.
REQ-010 In VERIFY, a mismatch on a nonzero word SHALL reload exp<=next(data_in), clear the match counter, and stay in VERIFY.
REQ-011 In VERIFY, a mismatch on an all-zero word SHALL return the state to SEARCH.
REQ-012 In LOCKED, every valid word SHALL advance exp<=next(exp), so the prediction is never resynchronized to bad data.
REQ-013 In LOCKED, a mismatch SHALL assert err_pulse_out for exactly the following cycle and increment err_count_out, holding at all-ones (saturation).
REQ-014 In LOCKED, a match SHALL clear the loss counter.
REQ-015 In LOCKED, the LOSS_COUNT-th consecutive mismatch SHALL force SEARCH; that word is still counted as an error.
REQ-016 locked_out and state_out SHALL be registered and reflect the new state the cycle after the deciding word.
REQ-017 clear_in=1 SHALL zero err_count_out and take priority over a simultaneous increment; state and exp are unaffected.
REQ-018 Match and loss counters SHALL be sized for their parameters and SHALL never wrap.

Reset
REQ-019 While rst_in=0 (asynchronous): state=SEARCH, exp=16'h0000, match/loss counters=0, locked_out=0, err_pulse_out=0, err_count_out=0, state_out=0.
REQ-020 Deasserting rst_in mid-stream SHALL restart acquisition from SEARCH at the next valid word.
REQ-021 Reset SHALL NOT require valid_in=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Stream 16'h8000 then its successors, valid every cycle -> second word expected 16'h8005; locked_out=1 one cycle after the 5th word (1 load + 4 matches); err_count_out=0.
- Seed 16'h0001 -> exp=16'h0002 after the first word; lock after 5 words; valid_in toggled 1/0 gives the same lock, delayed only by the idle cycles.
- Once locked, one word corrupted (bit 7 flipped) -> err_pulse_out high one cycle, err_count_out=1, locked_out stays 1, and the next correct word matches with no resync.
- Once locked, 3 consecutive corrupted words -> err_count_out=3, state_out=0 the cycle after the 3rd word, relock after 5 further good words.
- All-zero words in SEARCH -> state stays 0. Error counter at all-ones plus a further error -> stays all-ones. clear_in coincident with an error -> err_count_out=0.
- rst_in pulsed low mid-LOCKED, asynchronous to the clock -> all outputs zero immediately; normal reacquisition after release.
